// File: rtl/dmux_8_way_16_buf.sv
`default_nettype none
// ============================================================================
// Module   : dmux_8_way_16_buf
// Purpose  : 1-to-8 demultiplexer with a one-word buffer per channel.
//            A 16-bit word offered with a 3-bit select is steered into that
//            channel's holding register. The channel then flags it valid
//            until its reader takes it with a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module dmux_8_way_16_buf (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] in,
  input  logic [2:0]  select,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic [15:0] c,
  output logic [15:0] d,
  output logic [15:0] e,
  output logic [15:0] f,
  output logic [15:0] g,
  output logic [15:0] h,
  output logic [7:0]  out_valid,
  input  logic [7:0]  out_ready,
  output logic [15:0] xfer_count
);

  localparam int unsigned NUM_CH = 8;
  localparam int unsigned DATA_W = 16;

  logic [DATA_W-1:0] data_q [NUM_CH];
  logic [DATA_W-1:0] data_d [NUM_CH];
  logic [NUM_CH-1:0] valid_q;
  logic [NUM_CH-1:0] valid_d;
  logic [15:0]       count_q;
  logic [15:0]       count_d;
  logic              accept;

  // The selected slot can take a word when it is empty or is being drained
  // this cycle. Gating with rst_n keeps in_ready low for the whole reset.
  assign in_ready = rst_n & (~valid_q[select] | out_ready[select]);
  assign accept   = in_valid & in_ready;

  // Next state: drains clear valid flags, then an accept sets its flag
  // again. A same-cycle drain and accept on one slot therefore keeps it full.
  always_comb begin
    data_d  = data_q;
    valid_d = valid_q & ~out_ready;
    count_d = count_q;
    if (accept) begin
      data_d[select]  = in;
      valid_d[select] = 1'b1;
      count_d         = count_q + 16'd1;
    end
  end

  // State registers. Reset clears all held words at once.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= '0;
      end
      valid_q <= '0;
      count_q <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        data_q[i] <= data_d[i];
      end
      valid_q <= valid_d;
      count_q <= count_d;
    end
  end

  assign a          = data_q[0];
  assign b          = data_q[1];
  assign c          = data_q[2];
  assign d          = data_q[3];
  assign e          = data_q[4];
  assign f          = data_q[5];
  assign g          = data_q[6];
  assign h          = data_q[7];
  assign out_valid  = valid_q;
  assign xfer_count = count_q;

endmodule
`default_nettype wire

// File: doc/dmux_8_way_16_buf.md
DMUX_8_WAY_16_BUF -- requirements
Module: dmux_8_way_16_buf

Interface
REQ-001 Parameters SHALL be: none; data width is fixed at 16 bits and channel count at 8.
REQ-002 clk  input  1  single clock; all state SHALL change on its rising edge only.
REQ-003 rst_n  input  1  asynchronous, active-low reset; assertion SHALL take effect immediately, and deassertion SHALL be sampled on the clk rising edge.
REQ-004 in  input  16  write data word.
REQ-005 select  input  3  destination channel: 0=a, 1=b, ..., 7=h.
REQ-006 in_valid  input  1  writer offers in/select this cycle.
REQ-007 in_ready  output  1  block accepts in/select this cycle.
REQ-008 a, b, c, d, e, f, g, h  output  16 each  per-channel held data words.
REQ-009 out_valid  output  8  bit k high: channel k holds an undelivered word.
REQ-010 out_ready  input  8  bit k high: channel k reader takes its word this cycle.
REQ-011 xfer_count  output  16  count of words accepted since reset.

Function
REQ-012 Each channel k SHALL contain one 16-bit holding register and one valid flag (v[k]); out_valid[k] SHALL equal v[k], and channel output k SHALL equal holding register k.
REQ-013 in_ready SHALL be (rst_n high) AND (v[select]==0 OR out_ready[select]==1); it is combinational on select and out_ready, and does not depend on in_valid.
REQ-014 Accept SHALL mean in_valid AND in_ready at a rising edge; on accept, register[select] <= in and v[select] <= 1 at that edge, and no other channel's register SHALL change.
REQ-015 Drain SHALL mean v[k] AND out_ready[k] at a rising edge; on drain without a simultaneous accept to k, v[k] <= 0 and register k SHALL hold its value.
REQ-016 Simultaneous drain and accept on the same channel SHALL leave v[k]=1 and load the new word, giving full throughput of one word per cycle per channel.
REQ-017 Drains on different channels and an accept on any channel SHALL all occur independently in the same cycle.
REQ-018 Latency SHALL be exactly one cycle: a word accepted at edge N SHALL be visible on its channel output with out_valid[k]=1 after edge N.
REQ-019 While v[k]=1 and out_ready[k]=0, register k and v[k] SHALL remain stable.
REQ-020 When v[k]=0, output k SHALL hold the last word written to it (0 if never written); readers SHALL ignore it.
REQ-021 select and in are don't-care when in_valid=0; a stalled offer (in_valid=1, in_ready=0) SHALL cause no state change.
REQ-022 xfer_count SHALL increment by 1 on every accept and wrap from 0xFFFF to 0x0000.
REQ-023 Writing to one channel that is full and not draining SHALL NOT stall accepts offered to other channels on later cycles; head-of-line blocking is limited to the offered word.

Reset
REQ-024 While rst_n=0: all 8 registers SHALL be 0x0000, out_valid SHALL be 0x00, xfer_count SHALL be 0x0000, and in_ready SHALL be 0.
REQ-025 Reset asserted mid-operation SHALL discard all held words immediately, without waiting for a clock edge; no drain SHALL be reported for discarded words.
REQ-026 On the first edge after rst_n rises, the block SHALL accept a word if one is offered.

Verification
REQ-027 Route: after reset, offer in=0x1234, select=5, out_ready=0 for one cycle -> f=0x1234, out_valid=0x20, in_ready for select=5 drops to 0, and xfer_count=1.
REQ-028 Backpressure: with channel 5 full and out_ready=0, hold in=0xBEEF, select=5 for 3 cycles -> f stays 0x1234 and xfer_count stays 1; then raise out_ready[5] -> 0xBEEF is accepted on that edge, f=0xBEEF, and out_valid[5] stays 1.
REQ-029 Fan-out: offer 0x0000..0x0007 to select 0..7 on consecutive cycles with out_ready=0 -> out_valid=0xFF, outputs a..h=0..7, and in_ready=0 for every select.
REQ-030 Streaming: on channel 2 with out_ready[2]=1 held, offer 16 back-to-back words -> one word delivered per cycle in order, with no stall.
REQ-031 Reset mid-flow: with out_valid=0xFF, pulse rst_n low between edges -> all outputs 0x0000, out_valid=0x00, xfer_count=0, and in_ready=0 immediately.
REQ-032 Wrap: perform 65536 accepts -> xfer_count returns to 0x0000.
